// File: rtl/ram_ctrl_pkg.sv
// Shared types and default widths for the ram8 sweep controller.
// State encoding is fixed; 2'b11 is illegal and recovers to CLEAR.
package ram_ctrl_pkg;

  typedef enum logic [1:0] {
    CLEAR = 2'b00,
    IDLE  = 2'b01,
    FILL  = 2'b10
  } state_t;

  localparam int RAM_ADDR_W = 3;
  localparam int RAM_DATA_W = 16;

endpackage

// File: rtl/addr_sweep_counter.sv
// Address up-counter for the clear/fill sweeps.
// Synchronous clear wins over enable; o_last flags the all-ones count.
module addr_sweep_counter #(
  parameter int ADDR_WIDTH = 3
) (
  input  logic                  i_clk,
  input  logic                  i_rst_n,
  input  logic                  i_clr,
  input  logic                  i_en,
  output logic [ADDR_WIDTH-1:0] o_count,
  output logic                  o_last
);

  logic [ADDR_WIDTH-1:0] r_count;

  // Count up while sweeping; wraps naturally after all-ones.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_count <= '0;
    end else if (i_clr) begin
      r_count <= '0;
    end else if (i_en) begin
      r_count <= r_count + 1'b1;
    end
  end

  assign o_count = r_count;
  assign o_last  = &r_count;

endmodule

// File: rtl/ram_sweep_ctrl.sv
// Front-end for ram8: clears after reset, passes CPU accesses
// in IDLE, and sweeps a fill word on request.
module ram_sweep_ctrl
  import ram_ctrl_pkg::*;
#(
  parameter int ADDR_WIDTH = RAM_ADDR_W,
  parameter int DATA_WIDTH = RAM_DATA_W
) (
  input  logic                  clock,
  input  logic                  reset_n,
  input  logic [DATA_WIDTH-1:0] cpu_in,
  input  logic [ADDR_WIDTH-1:0] cpu_addr,
  input  logic                  cpu_load,
  output logic                  cpu_ready,
  input  logic                  fill_req,
  input  logic [DATA_WIDTH-1:0] fill_value,
  output logic                  busy,
  output logic                  done,
  output logic [DATA_WIDTH-1:0] ram_in,
  output logic [ADDR_WIDTH-1:0] ram_addr,
  output logic                  ram_load
);

  state_t                r_state;
  logic [DATA_WIDTH-1:0] r_fill_word;
  logic                  r_done;

  logic [ADDR_WIDTH-1:0] w_sweep_addr;
  logic                  w_last;
  logic                  w_sweeping;

  assign w_sweeping = (r_state == CLEAR) ||
                      (r_state == FILL);

  addr_sweep_counter #(
    .ADDR_WIDTH(ADDR_WIDTH)
  ) u_cnt (
    .i_clk   (clock),
    .i_rst_n (reset_n),
    .i_clr   (!w_sweeping),
    .i_en    (w_sweeping),
    .o_count (w_sweep_addr),
    .o_last  (w_last)
  );

  // Sequencer: sweep until last address, then idle until a fill request.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      r_state     <= CLEAR;
      r_fill_word <= '0;
      r_done      <= 1'b0;
    end else begin
      case (r_state)
        CLEAR, FILL: begin
          r_done <= w_last;
          if (w_last) begin
            r_state <= IDLE;
          end
        end
        IDLE: begin
          r_done <= 1'b0;
          if (fill_req) begin
            r_fill_word <= fill_value;
            r_state     <= FILL;
          end
        end
        default: begin
          r_done  <= 1'b0;
          r_state <= CLEAR;
        end
      endcase
    end
  end

  assign busy      = w_sweeping;
  assign cpu_ready = (r_state == IDLE);
  assign done      = r_done;

  // RAM port mux: CPU pass-through in IDLE, sweep address otherwise.
  always_comb begin
    ram_addr = w_sweep_addr;
    ram_in   = '0;
    ram_load = 1'b0;
    case (r_state)
      CLEAR: begin
        ram_load = 1'b1;
      end
      FILL: begin
        ram_in   = r_fill_word;
        ram_load = 1'b1;
      end
      IDLE: begin
        ram_addr = cpu_addr;
        ram_in   = cpu_in;
        ram_load = cpu_load;
      end
      default: begin
        ram_load = 1'b0;
      end
    endcase
  end

endmodule
